// File: rtl/fxyz_pkg.sv
// Shared types and constants for the fxyz truth-table sweep sequencer.
package fxyz_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

   localparam int unsigned FXYZ_NVEC  = 8;
   localparam logic [7:0]  FXYZ_TRUTH = 8'hAE;

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned ERR_W  = 4;
   localparam int unsigned WCNT_W = 4;
endpackage

// File: rtl/fxyz_settle_timer.sv
// Settle-time counter: counts cycles a vector has been held and flags the sample cycle.
module fxyz_settle_timer
   import fxyz_pkg::*;
#(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tc
);
   logic [WCNT_W-1:0] wcnt;

   assign tc = (wcnt == WCNT_W'(SETTLE - 1));

   // Wraps to zero on the sample cycle so the next vector starts its own count.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wcnt <= '0;
      end else if (en) begin
         wcnt <= tc ? '0 : wcnt + WCNT_W'(1);
      end
   end
endmodule

// File: rtl/fxyz_sweep.sv
// Sweeps {x,y,z} through 0..7, samples s after a settle time and checks the captured truth table.
module fxyz_sweep
   import fxyz_pkg::*;
#(
   parameter logic [7:0]  EXPECTED = FXYZ_TRUTH,
   parameter int unsigned SETTLE   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             s,
   output logic             x,
   output logic             y,
   output logic             z,
   output logic             busy,
   output logic             done,
   output logic [7:0]       table_out,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic             err_valid,
   output logic [IDX_W-1:0] first_err_idx
);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(FXYZ_NVEC - 1);

   state_t           state, state_next;
   logic [IDX_W-1:0] idx;
   logic             accept, strobe, tc, mismatch;
   logic [7:0]       captured;

   fxyz_settle_timer #(.SETTLE(SETTLE)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clear (accept),
      .en    (busy),
      .tc    (tc)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      strobe     = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               accept     = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            busy = 1'b1;
            if (tc) begin
               strobe = 1'b1;
               if (idx == LAST) state_next = DONE;
            end
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Table including the bit being sampled now, so pass can be ready for the done cycle.
   always_comb begin
      captured      = table_out;
      captured[idx] = s;
      mismatch      = (s != EXPECTED[idx]);
   end

   always_ff @(posedge clk) begin
      if (reset || accept) begin
         idx           <= '0;
         table_out     <= '0;
         pass          <= 1'b0;
         err_count     <= '0;
         err_valid     <= 1'b0;
         first_err_idx <= '0;
      end else if (strobe) begin
         table_out <= captured;
         if (mismatch) begin
            if (err_count != ERR_W'(FXYZ_NVEC)) err_count <= err_count + ERR_W'(1);
            err_valid <= 1'b1;
            if (!err_valid) first_err_idx <= idx;
         end
         if (idx == LAST) pass <= (captured == EXPECTED);
         else             idx  <= idx + IDX_W'(1);
      end
   end

   assign {x, y, z} = idx;
endmodule

// File: tb/tb_fxyz_sweep.sv
// Bench for fxyz_sweep: two instances (settle 1 and 3) driving table-defined functions.
module tb_fxyz_sweep;
   localparam int unsigned S0 = 1;
   localparam int unsigned S1 = 3;

   logic       clk = 1'b0;
   logic       reset [2];
   logic       start [2];
   logic       s     [2];
   logic [7:0] fn_tab[2];
   logic       x[2], y[2], z[2], busy[2], done[2], pass[2], err_valid[2];
   logic [7:0] tbl[2];
   logic [3:0] ec[2];
   logic [2:0] fei[2];
   int         settle[2] = '{S0, S1};
   int         tests = 0;
   int         fails = 0;

   always #5 clk = ~clk;

   // Function under test: a truth table looked up by {x,y,z}.
   always_comb begin
      for (int d = 0; d < 2; d++) s[d] = fn_tab[d][{x[d], y[d], z[d]}];
   end

   fxyz_sweep #(.EXPECTED(8'hAE), .SETTLE(S0)) u0 (
      .clk(clk), .reset(reset[0]), .start(start[0]), .s(s[0]),
      .x(x[0]), .y(y[0]), .z(z[0]), .busy(busy[0]), .done(done[0]),
      .table_out(tbl[0]), .pass(pass[0]), .err_count(ec[0]),
      .err_valid(err_valid[0]), .first_err_idx(fei[0])
   );

   fxyz_sweep #(.EXPECTED(8'hAE), .SETTLE(S1)) u1 (
      .clk(clk), .reset(reset[1]), .start(start[1]), .s(s[1]),
      .x(x[1]), .y(y[1]), .z(z[1]), .busy(busy[1]), .done(done[1]),
      .table_out(tbl[1]), .pass(pass[1]), .err_count(ec[1]),
      .err_valid(err_valid[1]), .first_err_idx(fei[1])
   );

   function automatic logic [7:0] ref_table();
      logic [7:0] t;
      logic       xi, yi, zi;
      for (int i = 0; i < 8; i++) begin
         xi   = ((i >> 2) & 1) != 0;
         yi   = ((i >> 1) & 1) != 0;
         zi   = (i & 1) != 0;
         t[i] = (yi | zi) & (~xi | zi);
      end
      return t;
   endfunction

   function automatic int popcnt(input logic [7:0] v);
      int n = 0;
      for (int i = 0; i < 8; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) if (v[i]) return i;
      return 0;
   endfunction

   task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, d, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input int d);
      chk("rst_vec",   d, {29'b0, x[d], y[d], z[d]}, 0);
      chk("rst_busy",  d, {31'b0, busy[d]}, 0);
      chk("rst_done",  d, {31'b0, done[d]}, 0);
      chk("rst_table", d, {24'b0, tbl[d]}, 0);
      chk("rst_pass",  d, {31'b0, pass[d]}, 0);
      chk("rst_errc",  d, {28'b0, ec[d]}, 0);
      chk("rst_errv",  d, {31'b0, err_valid[d]}, 0);
      chk("rst_first", d, {29'b0, fei[d]}, 0);
   endtask

   task automatic chk_results(input string tag, input int d, input logic [7:0] tab);
      logic [7:0] diff;
      diff = tab ^ ref_table();
      chk({tag, "_table"}, d, {24'b0, tbl[d]}, {24'b0, tab});
      chk({tag, "_pass"},  d, {31'b0, pass[d]}, (diff == 0) ? 1 : 0);
      chk({tag, "_errc"},  d, {28'b0, ec[d]}, popcnt(diff));
      chk({tag, "_errv"},  d, {31'b0, err_valid[d]}, (diff != 0) ? 1 : 0);
      chk({tag, "_first"}, d, {29'b0, fei[d]}, lowest(diff));
   endtask

   // Called at a negedge in IDLE; returns at a negedge in the IDLE cycle after done.
   task automatic sweep(input int d, input logic [7:0] tab, input bit hold_start);
      int n;
      n         = 8 * settle[d];
      fn_tab[d] = tab;
      start[d]  = 1'b1;
      @(posedge clk);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (!hold_start) start[d] = 1'b0;
         chk("busy", d, {31'b0, busy[d]}, 1);
         chk("done_early", d, {31'b0, done[d]}, 0);
         chk("vec", d, {29'b0, x[d], y[d], z[d]}, c / settle[d]);
      end
      @(negedge clk);
      chk("done", d, {31'b0, done[d]}, 1);
      chk("busy_done", d, {31'b0, busy[d]}, 0);
      chk_results("res", d, tab);
      @(negedge clk);
      chk("done_pulse", d, {31'b0, done[d]}, 0);
      chk("busy_idle", d, {31'b0, busy[d]}, 0);
      chk("vec_hold", d, {29'b0, x[d], y[d], z[d]}, 7);
      chk_results("held", d, tab);
   endtask

   initial begin
      logic [7:0] t;
      reset     = '{1'b1, 1'b1};
      start     = '{1'b0, 1'b0};
      fn_tab[0] = ref_table();
      fn_tab[1] = ref_table();
      repeat (3) @(negedge clk);
      reset = '{1'b0, 1'b0};
      for (int d = 0; d < 2; d++) chk_reset_state(d);
      repeat (4) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            chk("idle_done", d, {31'b0, done[d]}, 0);
            chk("idle_busy", d, {31'b0, busy[d]}, 0);
         end
      end

      sweep(0, ref_table(), 1'b0);
      sweep(0, 8'hFF, 1'b0);
      sweep(1, ref_table(), 1'b0);
      sweep(1, 8'h00, 1'b0);

      for (int r = 0; r < 4; r++) begin
         t = 8'($urandom);
         sweep(0, t, 1'b0);
         t = 8'($urandom);
         sweep(1, t, 1'b0);
      end

      // start held through a sweep: the next one must begin right after the idle cycle
      sweep(0, ref_table(), 1'b1);
      sweep(0, ref_table(), 1'b0);

      // reset while vector 4 is driven
      fn_tab[0] = 8'h5A;
      start[0]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start[0] = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_vec", 0, {29'b0, x[0], y[0], z[0]}, 4);
      reset[0] = 1'b1;
      @(negedge clk);
      reset[0] = 1'b0;
      chk_reset_state(0);
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_done", 0, {31'b0, done[0]}, 0);
      end
      sweep(0, ref_table(), 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
